// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse generator channel: IDLE/HIGH/LOW FSM with a phase down counter
// and shadow copies of H/L/mode that only change at a period boundary.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             mode,
  input  logic             trig,
  input  logic             sync,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] sh_h, sh_h_nxt;
  logic [CNT_W-1:0] sh_l, sh_l_nxt;
  logic             sh_mode, sh_mode_nxt;
  logic             done_nxt;
  logic             period_end;

  // State register, counter, shadow config and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh_h    <= '0;
      sh_l    <= '0;
      sh_mode <= MODE_CONT;
      pulse   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh_h    <= sh_h_nxt;
      sh_l    <= sh_l_nxt;
      sh_mode <= sh_mode_nxt;
      pulse   <= (state_nxt == HIGH);
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
    end
  end

  // Next-state logic: disable beats sync, sync beats normal sequencing.
  // Entering HIGH always loads the counter from the freshly latched shadow H.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_h_nxt    = sh_h;
    sh_l_nxt    = sh_l;
    sh_mode_nxt = sh_mode;
    done_nxt    = 1'b0;
    period_end  = 1'b0;

    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (sync && (mode == MODE_CONT)) begin
      sh_h_nxt    = high_len;
      sh_l_nxt    = low_len;
      sh_mode_nxt = MODE_CONT;
      if (high_len != '0) begin
        state_nxt = HIGH;
        cnt_nxt   = high_len - CNT_W'(1);
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if ((high_len != '0) && ((mode == MODE_CONT) || trig)) begin
            sh_h_nxt    = high_len;
            sh_l_nxt    = low_len;
            sh_mode_nxt = mode;
            state_nxt   = HIGH;
            cnt_nxt     = high_len - CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            if (sh_l != '0) begin
              state_nxt = LOW;
              cnt_nxt   = sh_l - CNT_W'(1);
            end else begin
              period_end = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt == '0) period_end = 1'b1;
          else           cnt_nxt    = cnt - CNT_W'(1);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase

      // A one-shot finishes here; a continuous channel picks up new config.
      if (period_end) begin
        if (sh_mode == MODE_ONESHOT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          sh_h_nxt    = high_len;
          sh_l_nxt    = low_len;
          sh_mode_nxt = mode;
          if ((high_len != '0) && (mode == MODE_CONT)) begin
            state_nxt = HIGH;
            cnt_nxt   = sh_h_nxt - CNT_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse/square-wave generator: NUM_CH independent
// channels sharing a clock, reset and phase-align sync.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       trig,
  input  logic                    sync,
  input  logic [NUM_CH*CNT_W-1:0] high_len,
  input  logic [NUM_CH*CNT_W-1:0] low_len,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  // One channel per slice of the packed length buses.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pulse_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (en[ch]),
      .mode    (mode[ch]),
      .trig    (trig[ch]),
      .sync    (sync),
      .high_len(high_len[ch*CNT_W +: CNT_W]),
      .low_len (low_len[ch*CNT_W +: CNT_W]),
      .pulse   (pulse[ch]),
      .busy    (busy[ch]),
      .done    (done[ch])
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: table of per-edge vectors plus hand sequences,
// expected outputs queued at drive time and popped after each edge.
module tb_pulse_gen_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst = 1'b1;
  logic [NUM_CH-1:0]       en = '0, mode = '0, trig = '0;
  logic                    sync = 1'b0;
  logic [NUM_CH*CNT_W-1:0] high_len = '0, low_len = '0;
  logic [NUM_CH-1:0]       pulse, busy, done;

  pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .mode    (mode),
    .trig    (trig),
    .sync    (sync),
    .high_len(high_len),
    .low_len (low_len),
    .pulse   (pulse),
    .busy    (busy),
    .done    (done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  en, mode, trig;
    logic        sync;
    logic [31:0] h, l;
    logic [3:0]  p, b, d;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] p, b, d;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input string nm, input logic r, input logic [3:0] e,
                              input logic [3:0] m, input logic [3:0] t, input logic s,
                              input logic [31:0] h, input logic [31:0] l,
                              input logic [3:0] p, input logic [3:0] b, input logic [3:0] d);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.mode = m; v.trig = t; v.sync = s;
    v.h = h; v.l = l; v.p = p; v.b = b; v.d = d;
    return v;
  endfunction

  task automatic cmp(input string nm, input string sig, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %b, expected %b", nm, sig, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: empty queue, got pulse=%b expected an entry", pulse);
    end else begin
      e = sb.pop_front();
      cmp(e.name, "pulse", pulse, e.p);
      cmp(e.name, "busy",  busy,  e.b);
      cmp(e.name, "done",  done,  e.d);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge sys_clk);
    sys_rst  = v.rst;
    en       = v.en;
    mode     = v.mode;
    trig     = v.trig;
    sync     = v.sync;
    high_len = v.h;
    low_len  = v.l;
    e.name = v.name; e.p = v.p; e.b = v.b; e.d = v.d;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    check_out();
  endtask

  task automatic step(input string nm, input logic r, input logic [3:0] e,
                      input logic [3:0] m, input logic [3:0] t, input logic s,
                      input logic [31:0] h, input logic [31:0] l,
                      input logic [3:0] p, input logic [3:0] b, input logic [3:0] d);
    apply(mk(nm, r, e, m, t, s, h, l, p, b, d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Lengths packed as {ch3, ch2, ch1, ch0} bytes.
    // Reset hold, release, then reset again mid-operation.
    vecs.push_back(mk("rst0",  1, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk("rst1",  1, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk("rst2",  1, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'h0, 4'h0, 4'h0));
    vecs.push_back(mk("rel0",  0, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mk("rel1",  0, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'h0, 4'hF, 4'h0));
    vecs.push_back(mk("rel2",  0, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'hF, 4'hF, 4'h0));
    vecs.push_back(mk("rst3",  1, 4'hF, 0, 0, 0, 32'h01010101, 32'h01010101, 4'h0, 4'h0, 4'h0));
    // ch0 H=1 L=1, ch1 H=3 L=1 continuous.
    vecs.push_back(mk("cont0", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("cont1", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h2, 4'h3, 4'h0));
    vecs.push_back(mk("cont2", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("cont3", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h0, 4'h3, 4'h0));
    vecs.push_back(mk("cont4", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("cont5", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h2, 4'h3, 4'h0));
    vecs.push_back(mk("cont6", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("cont7", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h0, 4'h3, 4'h0));
    vecs.push_back(mk("cont8", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("cont9", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h2, 4'h3, 4'h0));
    // ch1 H changed to 2 during the second high cycle of a period.
    vecs.push_back(mk("shad0", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("shad1", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h0, 4'h3, 4'h0));
    vecs.push_back(mk("shad2", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("shad3", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h2, 4'h3, 4'h0));
    vecs.push_back(mk("shad4", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h1, 4'h3, 4'h0));
    vecs.push_back(mk("shad5", 0, 4'h3, 0, 0, 0, 32'h00000201, 32'h00000101, 4'h2, 4'h3, 4'h0));
    // sync with ch1 back to H=3: both channels rise together.
    vecs.push_back(mk("sync0", 0, 4'h3, 0, 0, 1, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("sync1", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h2, 4'h3, 4'h0));
    vecs.push_back(mk("sync2", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    vecs.push_back(mk("sync3", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h0, 4'h3, 4'h0));
    vecs.push_back(mk("sync4", 0, 4'h3, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h3, 4'h3, 4'h0));
    // en[1] dropped mid-HIGH.
    vecs.push_back(mk("abort0", 0, 4'h1, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h0, 4'h1, 4'h0));
    vecs.push_back(mk("abort1", 0, 4'h1, 0, 0, 0, 32'h00000301, 32'h00000101, 4'h1, 4'h1, 4'h0));
    vecs.push_back(mk("rst4",   1, 4'h0, 0, 0, 0, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 4'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // One-shot ch2 H=4 L=2: retrig at t+2 ignored, retrig at t+7 restarts.
    step("os_t0", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    step("os_t1", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    step("os_t2", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    step("os_t3", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    step("os_t4", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h4, 4'h0);
    step("os_t5", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h4, 4'h0);
    step("os_t6", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h0, 4'h4);
    step("os_t7", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    for (int i = 0; i < 3; i++)
      step("os_hi", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h4, 4'h4, 4'h0);
    for (int i = 0; i < 2; i++)
      step("os_lo", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h4, 4'h0);
    step("os_done", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h0, 4'h4);
    step("os_after", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00040000, 32'h00020000, 4'h0, 4'h0, 4'h0);

    // ch3 continuous H=0 never starts.
    step("h0_a", 0, 4'h8, 4'h0, 4'h0, 0, 32'h00000000, 32'h03000000, 4'h0, 4'h0, 4'h0);
    step("h0_b", 0, 4'h8, 4'h0, 4'h0, 0, 32'h00000000, 32'h03000000, 4'h0, 4'h0, 4'h0);
    // ch3 H=5 L=0 stays high across the reload at each boundary.
    for (int i = 0; i < 7; i++)
      step("l0_hi", 0, 4'h8, 4'h0, 4'h0, 0, 32'h05000000, 32'h00000000, 4'h8, 4'h8, 4'h0);
    // H=0 arrives mid-period: remaining high cycles kept, then IDLE at boundary.
    for (int i = 0; i < 3; i++)
      step("l0_keep", 0, 4'h8, 4'h0, 4'h0, 0, 32'h00000000, 32'h00000000, 4'h8, 4'h8, 4'h0);
    step("l0_stop", 0, 4'h8, 4'h0, 4'h0, 0, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 4'h0);
    step("l0_idle", 0, 4'h8, 4'h0, 4'h0, 0, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 4'h0);

    // ch2 one-shot H=2 L=0: done at t+2.
    step("osl0_t0", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00020000, 32'h00000000, 4'h4, 4'h4, 4'h0);
    step("osl0_t1", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00020000, 32'h00000000, 4'h4, 4'h4, 4'h0);
    step("osl0_t2", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00020000, 32'h00000000, 4'h0, 4'h0, 4'h4);
    step("osl0_t3", 0, 4'h4, 4'h4, 4'h0, 0, 32'h00020000, 32'h00000000, 4'h0, 4'h0, 4'h0);
    // ch2 one-shot with H=0: trigger ignored.
    step("osh0_a", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00000000, 32'h00020000, 4'h0, 4'h0, 4'h0);
    step("osh0_b", 0, 4'h4, 4'h4, 4'h4, 0, 32'h00000000, 32'h00020000, 4'h0, 4'h0, 4'h0);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
Multi-channel programmable pulse/square-wave generator. Each channel drives a high phase of H cycles and a low phase of L cycles. Each channel runs in continuous or one-shot mode. Channel config is shadowed at every period boundary, so changes never corrupt a period in flight. A global sync input phase-aligns channels. The block sits beside the system clock domain and feeds timing/LED/test outputs.

Parameters:
NUM_CH, 4, number of independent channels
CNT_W, 8, width of high/low length fields; max phase length 2^CNT_W-1 cycles

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel enable
mode  in  NUM_CH  per-channel mode: 0 = continuous, 1 = one-shot
trig  in  NUM_CH  one-shot start request, level-sampled each edge
sync  in  1  restart all enabled continuous channels in phase
high_len  in  NUM_CH x CNT_W (packed)  high-phase length H per channel
low_len  in  NUM_CH x CNT_W (packed)  low-phase length L per channel
pulse  out  NUM_CH  generated waveform, registered
busy  out  NUM_CH  channel state != IDLE, registered
done  out  NUM_CH  1-cycle strobe at one-shot completion, registered

Behaviour:
- Reset: all channels go to IDLE. pulse=0, busy=0, done=0, counters=0, shadow regs=0.
- Priority per edge is sys_rst > en=0 > sync > normal operation.
- Per-channel FSM has states IDLE, HIGH, LOW.
- A down counter is loaded with len-1 on phase entry. The phase ends on the edge where the count is 0.
- Start condition (IDLE only), sampled at edge t:
  - Continuous start needs en=1, mode=0, H>0.
  - One-shot start needs en=1, mode=1, trig=1, H>0.
  - On start, H/L/mode are latched into shadow regs, state becomes HIGH and pulse becomes 1 at edge t.
- Timing:
  - pulse is 1 for edges t..t+H-1, exactly H cycles.
  - LOW then lasts L cycles; period is H+L.
  - H=1, L=1 gives a 50% duty wave of period 2.
- Period boundary is the end of LOW, or the end of HIGH when L=0. Continuous channels reload shadow H/L/mode there:
  - New H>0 and mode=0: seamless re-entry into HIGH.
  - New H=0 or mode=1: go to IDLE, pulse=0, no done.
- L=0 in continuous mode: LOW is skipped, so pulse stays constantly 1 (HIGH re-entered with reload every H cycles).
- One-shot:
  - Runs HIGH for H cycles, then LOW for L cycles.
  - At edge t+H+L, state goes to IDLE and done=1 for exactly one cycle.
  - If L=0, done occurs at edge t+H.
  - trig while busy is ignored. Earliest retrigger is sampled at the edge after done.
- H=0 at start: the request is ignored; pulse, busy and done stay 0.
- en falling mid-operation: the next edge gives IDLE, pulse=0, busy=0, no done.
- sync=1 at edge s, applied to every channel with en=1, mode=0:
  - Live H/L are re-sampled.
  - If H>0, state becomes HIGH with counter H-1 and pulse=1 at edge s.
  - If H=0, state becomes IDLE.
  - One-shot channels are unaffected.
- Live input changes mid-period never affect the current period, except through en and sync.
- busy = (state != IDLE). done is never asserted together with busy.

Decomposition:
- Package pulse_gen_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, HIGH, LOW}
  - localparams MODE_CONT=1'b0 and MODE_ONESHOT=1'b1
- Sub-module pulse_gen_ch implements one channel: FSM, counter, shadow regs, ports for one channel plus sync.
- pulse_gen_multi instantiates NUM_CH copies via generate and slices the packed buses.

Test Plan:
1. Reset: en=4'hF, mode=0, H=L=1, sys_rst=1 for 3 cycles -> pulse=busy=done=0 throughout. After release, pulse[0] starts 1 on the first edge.
2. Continuous waveforms:
   - ch0 H=1, L=1 -> pulse[0] is 1,0,1,0... (period 2).
   - ch1 H=3, L=1 -> 1,1,1,0 repeating (period 4, 75%).
3. Shadowing: ch1 H=3, L=1, change H to 2 during the 2nd high cycle -> the current period keeps 3 high cycles, the next period has 2 high + 1 low.
4. One-shot: ch2 H=4, L=2, trig 1 cycle at edge t -> pulse high t..t+3, low t+4..t+5, done=1 only at t+6, busy=1 t..t+5. A second trig at t+2 is ignored; trig at t+7 restarts.
5. Zero lengths:
   - ch3 continuous H=0 -> pulse stays 0, busy stays 0.
   - ch3 H=5, L=0 -> pulse constant 1.
   - ch2 one-shot H=2, L=0 -> done at t+2.
6. Abort and sync:
   - ch0 H=1, L=1 and ch1 H=3, L=1 free-running; pulse sync=1 at edge s -> both pulse=1 at s, rising edges aligned.
   - Then drop en[1] mid-HIGH -> pulse[1]=0 and busy[1]=0 on the next edge, no done.
